// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared types and constants for the multi-cycle RV32 sequencer:
//               opcode and funct3 encodings, yALU op codes, FSM state enum,
//               fault codes, instruction class enum and the latched IR struct.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

  // Major opcodes (ins[6:0])
  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  // yALU op codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // funct3 encodings that the sequencer understands
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_e;

  typedef enum logic [2:0] {
    CL_R   = 3'd0,
    CL_I   = 3'd1,
    CL_LD  = 3'd2,
    CL_ST  = 3'd3,
    CL_BR  = 3'd4,
    CL_JAL = 3'd5,
    CL_ILL = 3'd6
  } iclass_e;

  // Only the instruction fields the control path needs are kept.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
  } ir_t;

  function automatic logic is_mem_class(input iclass_e c);
    return (c == CL_LD) || (c == CL_ST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Bus between the sequencer and the yIF/yID/yEX/yDM/yWB
//               datapath.
// Signals     : ins, zero, pc_p4, jtarget, branch, mem_ready  (datapath -> ctrl)
//               pc, reg_write, alu_src, mem2reg, mem_read,
//               mem_write, alu_op                            (ctrl -> datapath)
// Modports    : master - the sequencer; slave - the datapath side
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if #(
  parameter int XLEN = 32
);
  logic [31:0]     ins;
  logic            zero;
  logic [XLEN-1:0] pc_p4;
  logic [XLEN-1:0] jtarget;
  logic [XLEN-1:0] branch;
  logic            mem_ready;

  logic [XLEN-1:0] pc;
  logic            reg_write;
  logic            alu_src;
  logic            mem2reg;
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      alu_op;

  modport master (
    input  ins, zero, pc_p4, jtarget, branch, mem_ready,
    output pc, reg_write, alu_src, mem2reg, mem_read, mem_write, alu_op
  );

  modport slave (
    output ins, zero, pc_p4, jtarget, branch, mem_ready,
    input  pc, reg_write, alu_src, mem2reg, mem_read, mem_write, alu_op
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_decode
// Description : Combinational instruction classifier. Maps the control fields
//               of an instruction to legality, class, yALU op and operand
//               select. Used for the legality check in DECODE and, fed from
//               the latched IR, for strobes and PC selection afterwards.
// Ports       : ir_i      - opcode / funct3 / ins[30]
//               legal_o   - 1 when the encoding is supported
//               iclass_o  - instruction class (CL_ILL when not legal)
//               alu_op_o  - yALU op code
//               alu_src_o - 1 selects the immediate operand
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  ir_t        ir_i,
  output logic       legal_o,
  output iclass_e    iclass_o,
  output logic [2:0] alu_op_o,
  output logic       alu_src_o
);

  always_comb begin
    iclass_o  = CL_ILL;
    alu_op_o  = ALU_ADD;
    alu_src_o = 1'b0;
    case (ir_i.opcode)
      OP_R: begin
        iclass_o = CL_R;
        case (ir_i.funct3)
          F3_ADDSUB: alu_op_o = ir_i.f7b5 ? ALU_SUB : ALU_ADD;
          F3_AND:    alu_op_o = ALU_AND;
          F3_OR:     alu_op_o = ALU_OR;
          F3_SLT:    alu_op_o = ALU_SLT;
          default:   iclass_o = CL_ILL;
        endcase
      end
      OP_I: begin
        iclass_o  = CL_I;
        alu_src_o = 1'b1;
      end
      OP_LD: begin
        iclass_o  = CL_LD;
        alu_src_o = 1'b1;
      end
      OP_ST: begin
        iclass_o  = CL_ST;
        alu_src_o = 1'b1;
      end
      OP_BR: begin
        alu_op_o = ALU_SUB;
        // Only beq/bne have a defined taken condition.
        if ((ir_i.funct3 == F3_BEQ) || (ir_i.funct3 == F3_BNE)) begin
          iclass_o = CL_BR;
        end
      end
      OP_JAL: begin
        iclass_o  = CL_JAL;
        alu_src_o = 1'b1;
      end
      default: iclass_o = CL_ILL;
    endcase
    legal_o = (iclass_o != CL_ILL);
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle sequencer for the RV32 datapath. Owns the PC,
//               steps FETCH/DECODE/EXEC/MEM/WB per instruction, drives the
//               datapath strobes, waits on mem_ready with a timeout, counts
//               retired instructions and reports a sticky fault.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               bus       - datapath bus (master side)
//               retired_o - retired-instruction count (wraps)
//               fault_o   - 00 none, 01 illegal opcode, 10 memory timeout
//               state_o   - current FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = 'h28,
  parameter int              MAX_WAIT = 8,
  parameter int              CNT_W    = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus,
  output logic [CNT_W-1:0]  retired_o,
  output logic [1:0]        fault_o,
  output logic [2:0]        state_o
);

  localparam int              WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_FULL = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  ir_t               ir_q, ir_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  fault_e            fault_q, fault_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  // --------------------------------------------------------------------------
  // Shared decoder: raw instruction fields while in DECODE (legality check),
  // the latched IR in every other state.
  // --------------------------------------------------------------------------
  ir_t        w_ins_ir;
  ir_t        w_dec_ir;
  logic       w_dec_legal;
  iclass_e    w_dec_iclass;
  logic [2:0] w_dec_alu_op;
  logic       w_dec_alu_src;
  logic       w_unused_ins;

  assign w_ins_ir.opcode = bus.ins[6:0];
  assign w_ins_ir.funct3 = bus.ins[14:12];
  assign w_ins_ir.f7b5   = bus.ins[30];
  assign w_unused_ins    = ^{bus.ins[31], bus.ins[29:15], bus.ins[11:7]};

  assign w_dec_ir = (state_q == S_DECODE) ? w_ins_ir : ir_q;

  multicycle_ctrl_decode u_decode (
    .ir_i      (w_dec_ir),
    .legal_o   (w_dec_legal),
    .iclass_o  (w_dec_iclass),
    .alu_op_o  (w_dec_alu_op),
    .alu_src_o (w_dec_alu_src)
  );

  // --------------------------------------------------------------------------
  // Next PC, evaluated from the latched IR whenever a PC update edge occurs.
  // --------------------------------------------------------------------------
  logic            w_br_taken;
  logic [XLEN-1:0] w_next_pc;

  assign w_br_taken = (ir_q.funct3 == F3_BEQ) ? bus.zero : ~bus.zero;

  always_comb begin
    w_next_pc = bus.pc_p4;
    case (w_dec_iclass)
      CL_JAL:  w_next_pc = pc_q + bus.jtarget;
      CL_BR:   w_next_pc = w_br_taken ? (pc_q + bus.branch) : bus.pc_p4;
      default: w_next_pc = bus.pc_p4;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      pc_q      <= PC_RESET;
      retired_q <= '0;
      fault_q   <= FAULT_NONE;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic w_pc_upd;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    wait_d    = wait_q;
    w_pc_upd  = 1'b0;

    case (state_q)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        ir_d = w_ins_ir;
        if (w_dec_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          if (fault_q == FAULT_NONE) fault_d = FAULT_ILLEGAL;
        end
      end

      S_EXEC: begin
        if (is_mem_class(w_dec_iclass)) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else if (w_dec_iclass == CL_BR) begin
          state_d  = S_FETCH;
          w_pc_upd = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        if (bus.mem_ready) begin
          wait_d = '0;
          if (w_dec_iclass == CL_LD) begin
            state_d = S_WB;
          end else begin
            state_d  = S_FETCH;
            w_pc_upd = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          // This is the MAX_WAIT-th unanswered MEM cycle.
          wait_d  = WAIT_FULL;
          state_d = S_HALT;
          if (fault_q == FAULT_NONE) fault_d = FAULT_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        state_d  = S_FETCH;
        w_pc_upd = 1'b1;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase

    if (w_pc_upd) begin
      pc_d      = w_next_pc;
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Moore strobes: a function of state and latched IR only.
  // --------------------------------------------------------------------------
  logic       w_reg_write;
  logic       w_alu_src;
  logic       w_mem2reg;
  logic       w_mem_read;
  logic       w_mem_write;
  logic [2:0] w_alu_op;

  always_comb begin
    w_reg_write = 1'b0;
    w_alu_src   = 1'b0;
    w_mem2reg   = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_alu_op    = ALU_ADD;
    case (state_q)
      S_EXEC: begin
        w_alu_op  = w_dec_alu_op;
        w_alu_src = w_dec_alu_src;
      end
      S_MEM: begin
        w_alu_op    = w_dec_alu_op;
        w_alu_src   = w_dec_alu_src;
        w_mem_read  = (w_dec_iclass == CL_LD);
        w_mem_write = (w_dec_iclass == CL_ST);
      end
      S_WB: begin
        w_alu_op    = w_dec_alu_op;
        w_alu_src   = w_dec_alu_src;
        w_reg_write = 1'b1;
        w_mem2reg   = (w_dec_iclass == CL_LD);
      end
      default: ;
    endcase
  end

  assign bus.pc        = pc_q;
  assign bus.reg_write = w_reg_write;
  assign bus.alu_src   = w_alu_src;
  assign bus.mem2reg   = w_mem2reg;
  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.alu_op    = w_alu_op;

  assign retired_o = retired_q;
  assign fault_o   = fault_q;
  assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. The stimulus process
//               issues directed instructions and queues the hand-computed
//               expected per-instruction response; a monitor process collects
//               what the sequencer did for each instruction and compares it
//               against the head of the queue when the instruction completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] retired;
  logic [1:0]  fault;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl_if #(.XLEN(32)) bus ();

  // yIF model: pc+4
  assign bus.pc_p4 = bus.pc + 32'd4;

  multicycle_ctrl #(
    .XLEN     (32),
    .PC_RESET (32'h28),
    .MAX_WAIT (8),
    .CNT_W    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .retired_o (retired),
    .fault_o   (fault),
    .state_o   (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  typedef struct {
    string       name;
    bit          chk_ex;
    logic [2:0]  alu_op;
    logic        alu_src;
    int          cycles;
    int          rd_cyc;
    int          wr_cyc;
    int          wb_cyc;
    logic        m2r;
    logic [31:0] pc;
    logic [15:0] ret;
    logic [1:0]  fault;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic any_strobe();
    return bus.reg_write | bus.alu_src | bus.mem2reg | bus.mem_read | bus.mem_write;
  endfunction

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  bit         in_instr = 1'b0;
  int         obs_cyc, obs_rd, obs_wr, obs_wb;
  bit         obs_ex, obs_bad, obs_drift;
  logic [2:0] obs_aluop;
  logic       obs_alusrc, obs_m2r;

  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow: instruction completed with no expected entry");
      return;
    end
    e = sb_q.pop_front();
    check({e.name, ".cycles"},    obs_cyc,  e.cycles);
    check({e.name, ".mem_read"},  obs_rd,   e.rd_cyc);
    check({e.name, ".mem_write"}, obs_wr,   e.wr_cyc);
    check({e.name, ".reg_write"}, obs_wb,   e.wb_cyc);
    check({e.name, ".mem2reg"},   obs_m2r,  e.m2r);
    check({e.name, ".pc"},        bus.pc,   e.pc);
    check({e.name, ".retired"},   retired,  e.ret);
    check({e.name, ".fault"},     fault,    e.fault);
    check({e.name, ".idle_strobes"}, obs_bad, 1'b0);
    if (e.chk_ex) begin
      check({e.name, ".saw_exec"}, obs_ex,     1'b1);
      check({e.name, ".alu_op"},   obs_aluop,  e.alu_op);
      check({e.name, ".alu_src"},  obs_alusrc, e.alu_src);
      check({e.name, ".alu_op_held"}, obs_drift, 1'b0);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_instr = 1'b0;
      end else if (state == 3'd0 || state == 3'd5) begin
        if (in_instr) sb_compare();
        in_instr = (state == 3'd0);
        obs_cyc   = 1;
        obs_rd    = 0;
        obs_wr    = 0;
        obs_wb    = 0;
        obs_ex    = 1'b0;
        obs_drift = 1'b0;
        obs_m2r   = 1'b0;
        obs_aluop = 3'b0;
        obs_alusrc = 1'b0;
        obs_bad   = any_strobe();
      end else if (in_instr) begin
        obs_cyc++;
        if (bus.mem_read)  obs_rd++;
        if (bus.mem_write) obs_wr++;
        if (bus.reg_write) begin
          obs_wb++;
          obs_m2r = bus.mem2reg;
        end
        if (state == 3'd1) obs_bad = obs_bad | any_strobe();
        if (state == 3'd2) begin
          obs_ex     = 1'b1;
          obs_aluop  = bus.alu_op;
          obs_alusrc = bus.alu_src;
        end
        if ((state == 3'd3 || state == 3'd4) && bus.alu_op !== obs_aluop) obs_drift = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  // Called at a negedge: holds reset across edges, checks reset state, then
  // releases just after a posedge so the next negedge shows FETCH.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ins       = 32'h0000_0013;
    bus.zero      = 1'b0;
    bus.branch    = 32'h0;
    bus.jtarget   = 32'h0;
    repeat (2) @(negedge clk);
    check("rst.pc",      bus.pc,      32'h28);
    check("rst.state",   state,       3'd0);
    check("rst.retired", retired,     16'd0);
    check("rst.fault",   fault,       2'b00);
    check("rst.strobes", any_strobe(), 1'b0);
    check("rst.alu_op",  bus.alu_op,  3'b010);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge where
  // the DUT is back in FETCH or has halted.
  task automatic run(input string name, input logic [31:0] ins, input logic z,
                     input logic [31:0] br, input logic [31:0] jt, input int waits,
                     input bit chk_ex, input logic [2:0] aluop, input logic alusrc,
                     input int cyc, input int rd, input int wr, input int wb,
                     input logic m2r, input logic [31:0] pc, input logic [15:0] ret,
                     input logic [1:0] flt);
    exp_t e;
    int   mem_k;
    bit   done;
    mem_k = 0;
    done  = 1'b0;
    check({name, ".start_in_fetch"}, state, 3'd0);
    bus.ins       = ins;
    bus.zero      = z;
    bus.branch    = br;
    bus.jtarget   = jt;
    bus.mem_ready = 1'b0;
    e.name = name;   e.chk_ex = chk_ex; e.alu_op = aluop; e.alu_src = alusrc;
    e.cycles = cyc;  e.rd_cyc = rd;     e.wr_cyc = wr;    e.wb_cyc = wb;
    e.m2r = m2r;     e.pc = pc;         e.ret = ret;      e.fault = flt;
    sb_q.push_back(e);
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (state == 3'd3) begin
        bus.mem_ready = (mem_k >= waits);
        mem_k++;
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (state == 3'd0 || state == 3'd5) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s.complete: still in state %0d after 60 cycles", name, state);
    end
  endtask

  task automatic check_frozen(input string name, input int n, input logic [31:0] pc,
                              input logic [15:0] ret, input logic [1:0] flt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({name, ".pc"},      bus.pc,       pc);
      check({name, ".retired"}, retired,      ret);
      check({name, ".fault"},   fault,        flt);
      check({name, ".state"},   state,        3'd5);
      check({name, ".strobes"}, any_strobe(), 1'b0);
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  localparam logic [31:0] I_ADD  = 32'h00B5_0533;
  localparam logic [31:0] I_SUB  = 32'h40B5_0533;
  localparam logic [31:0] I_AND  = 32'h00B5_7533;
  localparam logic [31:0] I_OR   = 32'h00B5_6533;
  localparam logic [31:0] I_SLT  = 32'h00B5_2533;
  localparam logic [31:0] I_SLL  = 32'h00B5_1533;
  localparam logic [31:0] I_ADDI = 32'h0015_0513;
  localparam logic [31:0] I_LW   = 32'h0003_2283;
  localparam logic [31:0] I_SW   = 32'h0053_2023;
  localparam logic [31:0] I_BEQ  = 32'h00B5_0863;
  localparam logic [31:0] I_BNE  = 32'h00B5_1863;
  localparam logic [31:0] I_BLT  = 32'h00B5_4863;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_BAD  = 32'h0000_007F;

  initial begin : stimulus
    bit found;
    rst_n = 1'b0;
    do_reset();

    //    name         ins     z     branch         jtarget        w  ex  aluop   src  cyc rd wr wb m2r  pc             ret     fault
    run("add",       I_ADD,  1'b0, 32'h0,         32'h0,         0, 1, 3'b010, 1'b0, 4, 0, 0, 1, 1'b0, 32'h0000_002C, 16'd1,  2'b00);
    run("lw_wait2",  I_LW,   1'b0, 32'h0,         32'h0,         2, 1, 3'b010, 1'b1, 7, 3, 0, 1, 1'b1, 32'h0000_0030, 16'd2,  2'b00);
    run("beq_taken", I_BEQ,  1'b1, 32'h10,        32'h0,         0, 1, 3'b110, 1'b0, 3, 0, 0, 0, 1'b0, 32'h0000_0040, 16'd3,  2'b00);
    run("beq_not",   I_BEQ,  1'b0, 32'h10,        32'h0,         0, 1, 3'b110, 1'b0, 3, 0, 0, 0, 1'b0, 32'h0000_0044, 16'd4,  2'b00);
    run("sub",       I_SUB,  1'b0, 32'h0,         32'h0,         0, 1, 3'b110, 1'b0, 4, 0, 0, 1, 1'b0, 32'h0000_0048, 16'd5,  2'b00);
    run("and",       I_AND,  1'b0, 32'h0,         32'h0,         0, 1, 3'b000, 1'b0, 4, 0, 0, 1, 1'b0, 32'h0000_004C, 16'd6,  2'b00);
    run("or",        I_OR,   1'b0, 32'h0,         32'h0,         0, 1, 3'b001, 1'b0, 4, 0, 0, 1, 1'b0, 32'h0000_0050, 16'd7,  2'b00);
    run("slt",       I_SLT,  1'b0, 32'h0,         32'h0,         0, 1, 3'b111, 1'b0, 4, 0, 0, 1, 1'b0, 32'h0000_0054, 16'd8,  2'b00);
    run("addi",      I_ADDI, 1'b0, 32'h0,         32'h0,         0, 1, 3'b010, 1'b1, 4, 0, 0, 1, 1'b0, 32'h0000_0058, 16'd9,  2'b00);
    run("sw",        I_SW,   1'b0, 32'h0,         32'h0,         0, 1, 3'b010, 1'b1, 4, 0, 1, 0, 1'b0, 32'h0000_005C, 16'd10, 2'b00);
    run("bne_taken", I_BNE,  1'b0, 32'hFFFF_FFF8, 32'h0,         0, 1, 3'b110, 1'b0, 3, 0, 0, 0, 1'b0, 32'h0000_0054, 16'd11, 2'b00);
    run("bne_not",   I_BNE,  1'b1, 32'hFFFF_FFF8, 32'h0,         0, 1, 3'b110, 1'b0, 3, 0, 0, 0, 1'b0, 32'h0000_0058, 16'd12, 2'b00);
    run("jal_back",  I_JAL,  1'b0, 32'h0,         32'hFFFF_FFF0, 0, 1, 3'b010, 1'b1, 4, 0, 0, 1, 1'b0, 32'h0000_0048, 16'd13, 2'b00);
    run("lw_nowait", I_LW,   1'b0, 32'h0,         32'h0,         0, 1, 3'b010, 1'b1, 5, 1, 0, 1, 1'b1, 32'h0000_004C, 16'd14, 2'b00);
    run("illegal",   I_BAD,  1'b0, 32'h0,         32'h0,         0, 0, 3'b010, 1'b0, 2, 0, 0, 0, 1'b0, 32'h0000_004C, 16'd14, 2'b01);
    check_frozen("halt_ill", 20, 32'h0000_004C, 16'd14, 2'b01);

    do_reset();
    run("ill_rtype", I_SLL,  1'b0, 32'h0,         32'h0,         0, 0, 3'b010, 1'b0, 2, 0, 0, 0, 1'b0, 32'h0000_0028, 16'd0,  2'b01);
    check_frozen("halt_sll", 2, 32'h0000_0028, 16'd0, 2'b01);

    do_reset();
    run("ill_branch", I_BLT, 1'b0, 32'h0,         32'h0,         0, 0, 3'b010, 1'b0, 2, 0, 0, 0, 1'b0, 32'h0000_0028, 16'd0,  2'b01);

    // Asynchronous reset while a load is waiting in MEM.
    do_reset();
    bus.ins       = I_LW;
    bus.mem_ready = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (state == 3'd3) found = 1'b1;
    end
    check("midmem.reached_mem", found, 1'b1);
    check("midmem.mem_read_before", bus.mem_read, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("midmem.mem_read_after", bus.mem_read, 1'b0);
    check("midmem.state_after",    state,        3'd0);
    check("midmem.pc_after",       bus.pc,       32'h28);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Store that never gets mem_ready: eight MEM cycles then a timeout halt.
    run("sw_timeout", I_SW, 1'b0, 32'h0,          32'h0,      1000, 1, 3'b010, 1'b1, 11, 0, 8, 0, 1'b0, 32'h0000_0028, 16'd0, 2'b10);
    check("timeout.mem_write_dropped", bus.mem_write, 1'b0);
    check_frozen("halt_tmo", 3, 32'h0000_0028, 16'd0, 2'b10);

    check("sb_leftover", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
